// File: rtl/mem_arbiter2.sv
// mem_arbiter2: two-master PicoRV32 memory arbiter with watchdog; MEM_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module mem_arbiter2 #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  m0_valid,
  input  logic                  m0_instr,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  input  logic [3:0]            m0_wstrb,
  output logic                  m0_ready,
  output logic [31:0]           m0_rdata,
  input  logic                  m1_valid,
  input  logic                  m1_instr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  input  logic [3:0]            m1_wstrb,
  output logic                  m1_ready,
  output logic [31:0]           m1_rdata,
  output logic                  s_valid,
  output logic                  s_instr,
  output logic [ADDR_WIDTH-1:0] s_addr,
  output logic [31:0]           s_wdata,
  output logic [3:0]            s_wstrb,
  input  logic                  s_ready,
  input  logic [31:0]           s_rdata,
  output logic                  timeout_err,
  output logic [31:0]           grant_cnt0,
  output logic [31:0]           grant_cnt1
);
  localparam logic [1:0] IDLE = 2'd0, BUSY0 = 2'd1, BUSY1 = 2'd2, RELEASE = 2'd3;
  localparam int WW = $clog2(TIMEOUT_CYCLES);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);
  logic [1:0] state;
  logic [WW-1:0] wd;
  logic busy, expire, done, req, pick1;
  assign busy = state == BUSY0 || state == BUSY1;
  assign expire = wd == WD_LAST;
  assign done = resetn && busy && (s_ready || expire);
  assign req = m0_valid || m1_valid;
  assign s_valid = busy;
  assign m0_ready = done && state == BUSY0;
  assign m1_ready = done && state == BUSY1;
  assign m0_rdata = m0_ready && s_ready ? s_rdata : '0;
  assign m1_rdata = m1_ready && s_ready ? s_rdata : '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic rr_pri;
  assign pick1 = m1_valid && (!m0_valid || rr_pri);
  // priority flips to the master not granted on each grant
  always_ff @(posedge clock)
    if (!resetn) rr_pri <= 1'b0;
    else if (state == IDLE && req) rr_pri <= !pick1;
`else
  assign pick1 = m1_valid && !m0_valid;
`endif
  // grant FSM, request latch, watchdog and completion counters
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
      wd <= '0;
      s_instr <= 1'b0;
      s_addr <= '0;
      s_wdata <= '0;
      s_wstrb <= '0;
      timeout_err <= 1'b0;
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else begin
      if (state == IDLE) begin
        if (req) begin
          state <= pick1 ? BUSY1 : BUSY0;
          s_instr <= pick1 ? m1_instr : m0_instr;
          s_addr <= pick1 ? m1_addr : m0_addr;
          s_wdata <= pick1 ? m1_wdata : m0_wdata;
          s_wstrb <= pick1 ? m1_wstrb : m0_wstrb;
          wd <= '0;
        end
      end else if (busy) begin
        wd <= wd + 1'b1;
        if (s_ready || expire) state <= RELEASE;
        if (!s_ready && expire) timeout_err <= 1'b1;
      end else begin
        state <= IDLE;
      end
      if (m0_ready) grant_cnt0 <= grant_cnt0 + 1;
      if (m1_ready) grant_cnt1 <= grant_cnt1 + 1;
    end
  end
endmodule
